// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state type and sizing helpers for the
// round-robin parallel-to-serial scheduler.
package p2s_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF = 4;
    localparam int GAP_DEF = 1;

    // Never returns 0, so a counter for a 0/1 range still gets one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int BIT_W = cnt_w(WIDTH_DEF);
    localparam int ID_W = cnt_w(NREQ_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } p2s_sched_state_t;

endpackage

// File: rtl/p2s_sched_if.sv
// p2s_sched_if: requester handshake plus serializer control bundle.
// slave is the scheduler side, master the requester/serializer side.
interface p2s_sched_if #(
    parameter int WIDTH = p2s_pkg::WIDTH_DEF,
    parameter int NREQ = p2s_pkg::NREQ_DEF
);

    localparam int BW = p2s_pkg::cnt_w(WIDTH);
    localparam int IW = p2s_pkg::cnt_w(NREQ);

    logic [NREQ-1:0] req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic [WIDTH-1:0] ser_word;
    logic [BW-1:0] ser_bit_sel;
    logic shift_en;
    logic ser_frame;
    logic [IW-1:0] ser_id;
    logic done;
    logic busy;

    modport master (
        output req_valid,
        output req_data,
        input req_ready,
        input ser_word,
        input ser_bit_sel,
        input shift_en,
        input ser_frame,
        input ser_id,
        input done,
        input busy
    );

    modport slave (
        input req_valid,
        input req_data,
        output req_ready,
        output ser_word,
        output ser_bit_sel,
        output shift_en,
        output ser_frame,
        output ser_id,
        output done,
        output busy
    );

endinterface

// File: rtl/p2s_rr_arb.sv
// p2s_rr_arb: combinational round-robin pick starting at ptr,
// wrapping modulo NREQ; one-hot grant plus its index.
module p2s_rr_arb
    import p2s_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW = cnt_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id
);

    int j;
    logic [IW-1:0] jj;

    // Walk from farthest to nearest so the slot at ptr wins last.
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        j = 0;
        jj = '0;
        if (en) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                j = int'(ptr) + i;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
                jj = IW'(j);
                if (req[jj]) begin
                    gnt = '0;
                    gnt[jj] = 1'b1;
                    gnt_id = jj;
                end
            end
        end
    end

endmodule

// File: rtl/p2s_sched.sv
// p2s_sched: shares one serializer among NREQ requesters, one
// WIDTH-bit word per frame, LSB first, GAP idle cycles between.
module p2s_sched
    import p2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int GAP = GAP_DEF
) (
    input logic       sys_clk,
    input logic       sys_rst_n,
    input logic       ctrl_en,
    p2s_sched_if.slave bus
);

    localparam int BW = cnt_w(WIDTH);
    localparam int IW = cnt_w(NREQ);
    localparam int GW = cnt_w(GAP);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LD =
        (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [IW-1:0] ID_MAX = IW'(NREQ - 1);

    p2s_sched_state_t state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    id_q, id_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             arb_en;
    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_id;

    // Grants only from IDLE, and never while reset is held.
    assign arb_en = sys_rst_n & ctrl_en & (state_q == S_IDLE);

    p2s_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req(bus.req_valid),
        .ptr(ptr_q),
        .en(arb_en),
        .gnt(gnt),
        .gnt_id(gnt_id)
    );

    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ptr_d = ptr_q;
        word_d = word_q;
        id_d = id_q;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    state_d = S_SHIFT;
                    bit_cnt_d = '0;
                    word_d = bus.req_data[int'(gnt_id) * WIDTH +: WIDTH];
                    id_d = gnt_id;
                    ptr_d = (gnt_id == ID_MAX) ? '0 : gnt_id + 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST) begin
                    done_d = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = GAP_LD;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        shift_d = (state_d == S_SHIFT);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ptr_q <= '0;
            word_q <= '0;
            id_q <= '0;
            shift_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q <= ptr_d;
            word_q <= word_d;
            id_q <= id_d;
            shift_q <= shift_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.ser_word = word_q;
    assign bus.ser_bit_sel = bit_cnt_q;
    assign bus.shift_en = shift_q;
    assign bus.ser_frame = shift_q;
    assign bus.ser_id = id_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

    a_gnt_onehot: assert property (
        @(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(gnt)
    );

    a_gnt_idle: assert property (
        @(posedge sys_clk) disable iff (!sys_rst_n)
        (|gnt) |-> (state_q == S_IDLE)
    );

endmodule

// File: tb/tb_p2s_sched.sv
// tb_p2s_sched: directed scenarios plus random traffic, checked
// every cycle against a frame-timeline model of the scheduler.
module tb_p2s_sched;

    localparam int W = 8;
    localparam int N = 4;
    localparam int G = 1;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic ctrl_en = 1'b0;

    always #5 sys_clk = ~sys_clk;

    p2s_sched_if #(.WIDTH(W), .NREQ(N)) if0 ();
    p2s_sched_if #(.WIDTH(W), .NREQ(N)) if1 ();

    p2s_sched #(.WIDTH(W), .NREQ(N), .GAP(G)) u0 (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .ctrl_en(ctrl_en),
        .bus(if0)
    );

    p2s_sched #(.WIDTH(W), .NREQ(N), .GAP(0)) u1 (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .ctrl_en(ctrl_en),
        .bus(if1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // Model: a frame is fully described by its accept cycle.
    int ncyc = 0;
    bit m_act = 1'b0;
    int m_t = 0;
    int m_ptr = 0;
    int m_id = 0;
    logic [W-1:0] m_word = '0;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    always @(negedge sys_clk) begin
        int rel, k;
        logic [N-1:0] e_rdy;
        if (!sys_rst_n) begin
            chk("rst req_ready", if0.req_ready, 0);
            chk("rst shift_en", if0.shift_en, 0);
            chk("rst ser_frame", if0.ser_frame, 0);
            chk("rst done", if0.done, 0);
            chk("rst busy", if0.busy, 0);
            chk("rst ser_word", if0.ser_word, 0);
            chk("rst ser_id", if0.ser_id, 0);
            chk("rst ser_bit_sel", if0.ser_bit_sel, 0);
            m_act = 1'b0;
            m_ptr = 0;
            m_id = 0;
            m_word = '0;
        end else begin
            rel = m_act ? ncyc - m_t : (1 << 20);
            e_rdy = '0;
            k = -1;
            if ((rel < 1 || rel > W + G) && ctrl_en)
                k = rr_pick(if0.req_valid, m_ptr);
            if (k >= 0) e_rdy[k] = 1'b1;
            chk("req_ready", if0.req_ready, e_rdy);
            chk("shift_en", if0.shift_en, rel >= 1 && rel <= W);
            chk("ser_frame", if0.ser_frame, rel >= 1 && rel <= W);
            if (rel >= 1 && rel <= W)
                chk("ser_bit_sel", if0.ser_bit_sel, rel - 1);
            chk("done", if0.done, rel == W + 1);
            chk("busy", if0.busy, rel >= 1 && rel <= W + G);
            chk("ser_word", if0.ser_word, m_word);
            chk("ser_id", if0.ser_id, m_id);
            if (k >= 0) begin
                m_act = 1'b1;
                m_t = ncyc;
                m_word = if0.req_data[k*W +: W];
                m_id = k;
                m_ptr = (k + 1) % N;
            end
        end
        ncyc++;
    end

    logic [N-1:0] r_rdy, r1_rdy;
    logic r_shift, r_done, r_busy, r1_shift, r1_done;
    logic [2:0] r_sel;
    logic [1:0] r_id;
    logic [W-1:0] r_word;

    // mode 0: keep valid, new data on accept; 1: drop on accept; 2: random
    task automatic cyc_t(input int mode);
        logic [N-1:0] g0, g1;
        @(negedge sys_clk);
        r_rdy = if0.req_ready;
        r_shift = if0.shift_en;
        r_done = if0.done;
        r_busy = if0.busy;
        r_sel = if0.ser_bit_sel;
        r_id = if0.ser_id;
        r_word = if0.ser_word;
        r1_rdy = if1.req_ready;
        r1_shift = if1.shift_en;
        r1_done = if1.done;
        g0 = r_rdy;
        g1 = r1_rdy;
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (g1[k]) if1.req_data[k*W +: W] = W'($urandom);
            if (g0[k]) begin
                if (mode == 1) if0.req_valid[k] = 1'b0;
                else if (mode == 2) if0.req_valid[k] = 1'($urandom_range(0, 1));
                if0.req_data[k*W +: W] = W'($urandom);
            end else if (mode == 2) begin
                if (if0.req_valid[k]) begin
                    if ($urandom_range(0, 19) == 0) if0.req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if0.req_valid[k] = 1'b1;
                    if0.req_data[k*W +: W] = W'($urandom);
                end
            end
        end
        if (mode == 2) begin
            if (!sys_rst_n) sys_rst_n = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 499) == 0) sys_rst_n = 1'b0;
            if ($urandom_range(0, 39) == 0) ctrl_en = ~ctrl_en;
        end
    endtask

    task automatic wait_gnt(input int mode, output int id);
        int n;
        n = 0;
        id = -1;
        do begin
            cyc_t(mode);
            n++;
        end while (r_rdy == '0 && n < 40);
        chk("grant seen", r_rdy != '0, 1);
        for (int k = 0; k < N; k++)
            if (r_rdy[k]) id = k;
    endtask

    initial begin
        int id, nd, nr, ns, n;
        logic sh[0:11];
        logic dn[0:11];
        logic [N-1:0] rd[0:11];
        if0.req_valid = '0;
        if0.req_data = '0;
        if1.req_valid = '0;
        if1.req_data = '0;
        cyc_t(1);
        cyc_t(1);
        chk("reset ready", r_rdy, 0);
        chk("reset shift", r_shift, 0);
        chk("reset busy", r_busy, 0);
        chk("reset word", r_word, 0);
        sys_rst_n = 1'b1;
        ctrl_en = 1'b1;

        // single word from requester 2
        if0.req_valid = 4'b0100;
        if0.req_data[2*W +: W] = 8'hA5;
        wait_gnt(1, id);
        chk("A grant id", id, 2);
        chk("A ready", r_rdy, 4'b0100);
        if0.req_valid[2] = 1'b1;
        if0.req_data[2*W +: W] = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            cyc_t(1);
            chk("A shift", r_shift, 1);
            chk("A bit_sel", r_sel, i);
            chk("A word", r_word, 8'hA5);
            chk("A id", r_id, 2);
            chk("A no ready in frame", r_rdy, 0);
        end
        cyc_t(1);
        chk("A done", r_done, 1);
        chk("A ready in gap", r_rdy, 0);
        cyc_t(1);
        chk("A next grant", r_rdy, 4'b0100);

        // GAP=0 back-to-back on the second instance
        if1.req_valid = 4'b0011;
        n = 0;
        do begin
            cyc_t(1);
            n++;
        end while (r1_rdy == '0 && n < 20);
        chk("C first grant", r1_rdy, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            cyc_t(1);
            sh[i] = r1_shift;
            dn[i] = r1_done;
            rd[i] = r1_rdy;
        end
        ns = 0;
        for (int i = 0; i < 8; i++) ns += int'(sh[i]);
        chk("C shifts", ns, 8);
        chk("C done", dn[8], 1);
        chk("C ready with done", rd[8], 4'b0010);
        chk("C shift gap", sh[8], 0);
        chk("C second frame", sh[9], 1);
        if1.req_valid = '0;

        // all requesters valid: strict rotation from ptr 0
        sys_rst_n = 1'b0;
        cyc_t(1);
        cyc_t(1);
        sys_rst_n = 1'b1;
        if0.req_valid = 4'hF;
        for (int g = 0; g < 6; g++) begin
            wait_gnt(0, id);
            chk("B order", id, g % 4);
        end

        // ctrl_en drop inside a frame
        wait_gnt(0, id);
        chk("D grant", id, 2);
        ns = 0;
        cyc_t(0);
        ns += int'(r_shift);
        cyc_t(0);
        ns += int'(r_shift);
        ctrl_en = 1'b0;
        nd = 0;
        nr = 0;
        for (int i = 0; i < 30; i++) begin
            cyc_t(0);
            ns += int'(r_shift);
            nd += int'(r_done);
            nr += int'(r_rdy != '0);
        end
        chk("D shifts", ns, 8);
        chk("D done", nd, 1);
        chk("D ready while off", nr, 0);
        ctrl_en = 1'b1;
        wait_gnt(0, id);
        chk("D resume", id, 3);

        // reset in the 5th shift cycle
        wait_gnt(0, id);
        chk("E grant", id, 0);
        for (int i = 0; i < 4; i++) cyc_t(0);
        sys_rst_n = 1'b0;
        cyc_t(0);
        chk("E shift", r_shift, 0);
        chk("E busy", r_busy, 0);
        chk("E word", r_word, 0);
        chk("E id", r_id, 0);
        chk("E sel", r_sel, 0);
        chk("E ready", r_rdy, 0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_t(0);
            nd += int'(r_done);
        end
        chk("E no done", nd, 0);
        sys_rst_n = 1'b1;
        wait_gnt(0, id);
        chk("E ptr reset", id, 0);

        // requester 1 withdraws while ptr is 1
        if0.req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) cyc_t(1);
        if0.req_valid[1] = 1'b0;
        wait_gnt(1, id);
        chk("F skip to 3", id, 3);
        if0.req_valid = 4'hF;
        wait_gnt(1, id);
        chk("F wrap to 0", id, 0);

        // random traffic, enable toggles and resets
        if0.req_valid = '0;
        for (int i = 0; i < 2500; i++) cyc_t(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/p2s_sched.md
# p2s_sched

Round-robin scheduler that shares one parallel-to-serial datapath (the `p2s` serializer) between `NREQ` word requesters. It accepts one `WIDTH`-bit word at a time over a valid/ready handshake and holds that word stable. It then sequences the serializer for exactly `WIDTH` shift cycles, LSB first, and inserts `GAP` idle cycles between words. It sits between the requester blocks and the serializer, and it is the only agent that drives `shift_en`.

## Interface
- `WIDTH`, 8, word width in bits; minimum 2.
- `NREQ`, 4, number of requesters; minimum 2.
- `GAP`, 1, idle cycles inserted after each word; 0 allowed.
- `sys_clk`  in  1  system clock, rising edge.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `ctrl_en`  in  1  when 0, no new grants; a word in flight completes.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*WIDTH  requester k word at `[k*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot accept strobe; combinational.
- `ser_word`  out  WIDTH  captured word, stable for the whole frame.
- `ser_bit_sel`  out  clog2(WIDTH)  index of the bit being shifted.
- `shift_en`  out  1  serializer shift enable.
- `ser_frame`  out  1  high exactly while `shift_en` is high.
- `ser_id`  out  clog2(NREQ)  owner of the current word.
- `done`  out  1  one-cycle pulse after a word's last bit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - If `ctrl_en` is 1 and any `req_valid` is 1, the round-robin arbiter picks winner k.
  - `req_ready[k]` = 1 in the same cycle.
  - The word from `req_data` is captured into `ser_word` and k into `ser_id`.
  - `bit_cnt` is set to 0 and the FSM goes to SHIFT.
- **SHIFT**
  - `shift_en` = `ser_frame` = 1 and `ser_bit_sel` = `bit_cnt`.
  - `bit_cnt` increments each cycle.
  - At `bit_cnt` == WIDTH-1: `done` is pulsed next cycle, the FSM goes to GAP (GAP>0) or IDLE (GAP=0), and `gap_cnt` is loaded with GAP-1.
- **GAP**: counts `gap_cnt` down to 0, then goes to IDLE. `shift_en` stays 0.
- **Round robin**
  - Priority pointer `ptr` resets to 0.
  - The search runs from `ptr` upward and wraps modulo NREQ.
  - After a grant to k, `ptr` = (k+1) mod NREQ. At k=NREQ-1 it wraps to 0.
  - `ptr` is unchanged when there is no grant.
- **Handshake**
  - A requester holds valid and data stable until it sees ready.
  - Dropping valid before ready is legal; no grant results.
  - `req_ready` is never high outside IDLE, and never high while `ctrl_en` = 0.
- `ctrl_en` falling during SHIFT or GAP: the frame and gap complete normally, then the block stays in IDLE.
- `req_valid` changing during SHIFT is ignored; arbitration samples only in IDLE.
- **Reset**, including mid-frame: the word is abandoned and no `done` pulse is produced. Reset values:
  - FSM = IDLE, `ptr` = 0.
  - `ser_word`, `ser_bit_sel`, `ser_id`, `bit_cnt`, `gap_cnt` = 0.
  - `shift_en`, `ser_frame`, `done`, `busy` = 0.
  - `req_ready` = 0.

## Timing
- Accept in cycle T (`req_ready` high).
- `shift_en` is high in cycles T+1 … T+WIDTH, with `ser_bit_sel` = 0 … WIDTH-1.
- `done` is high in cycle T+WIDTH+1 only.
- The next accept is possible at earliest cycle T+WIDTH+1+GAP. With GAP=0, `done` and the next `req_ready` coincide.
- Throughput: one word per WIDTH+1+GAP cycles under continuous demand.
- All outputs are registered except `req_ready`, which is a function of state, `ctrl_en`, `req_valid` and `ptr`.
- `busy` is high from T+1 until the cycle the FSM re-enters IDLE.

## Structure
- Package `p2s_pkg` holds:
  - the state enum `p2s_sched_state_t` (IDLE, SHIFT, GAP);
  - the default localparams for WIDTH, NREQ and GAP;
  - the width helpers `BIT_W` = clog2(WIDTH) and `ID_W` = clog2(NREQ).
- Sub-module `p2s_rr_arb`:
  - inputs: `req[NREQ]`, `ptr`, `en`;
  - outputs: one-hot `gnt` and `gnt_id`;
  - purely combinational.
- `p2s_sched` owns the FSM, the counters, `ptr` and the word register.

## Test plan
- **Single word:** reset, then requester 2 valid with 0xA5 and GAP=1 → `req_ready[2]` in cycle T; `ser_word` = 0xA5 and `ser_id` = 2; `ser_bit_sel` 0..7 over T+1..T+8; `done` at T+9; next grant no earlier than T+10.
- **All requesters valid continuously, NREQ=4:** grant order 0,1,2,3,0,1.
- **GAP=0 back-to-back:** requesters 0 and 1 valid → `done` for word 0 and `req_ready[1]` in the same cycle; `shift_en` low for exactly 1 cycle between frames.
- **`ctrl_en` dropped at the 3rd shift cycle:** all 8 shifts complete and `done` pulses; then no `req_ready` while `ctrl_en` = 0; after `ctrl_en` = 1 the grant resumes at (last k)+1.
- **Reset asserted at the 5th shift cycle:** all outputs 0 immediately; no `done`; after release, requester 0 wins first (`ptr` = 0).
- **Requester 1 drops valid before grant while requester 3 is valid (`ptr` = 1):** grant goes to 3, and `ptr` becomes 0.
